dec_exe_pipe: RTL and testbench
===============================

// Module: dec_exe_pipe
// PURPOSE
//  Decode->execute pipeline register; downstream consumer of bypass_ctrl outputs.
//  Per operand, selects bypass data or register-file data.
//  Inserts NOP bubbles on stall_core and on flush.
//  Watches for runaway stalls.
// PARAMETERS
//  XLEN          32   datapath width
//  STALL_TIMEOUT 64   consecutive stall cycles before stall_timeout_o sets (>=2)
// PORTS
//  clk_i              in   1     clock; all state updates on rising edge
//  rsn_i              in   1     reset, synchronous, active-low
//  dec_valid_i        in   1     decode slot holds a real instruction
//  dec_pc_i           in   XLEN  decode PC
//  dec_instr_i        in   32    decode instruction word
//  dec_read_addr_a_i  in   5     rs1 address
//  dec_read_addr_b_i  in   5     rs2 address
//  rf_data_a_i        in   XLEN  register-file rs1 data
//  rf_data_b_i        in   XLEN  register-file rs2 data
//  dec_imm_i          in   XLEN  decoded immediate
//  dec_wr_addr_i      in   5     rd
//  dec_wr_en_i        in   1     instruction writes rd
//  bypass_a_en_i      in   1     from bypass_ctrl
//  bypass_b_en_i      in   1     from bypass_ctrl
//  bypass_data_a_i    in   XLEN  from bypass_ctrl
//  bypass_data_b_i    in   XLEN  from bypass_ctrl
//  stall_core_i       in   1     from bypass_ctrl
//  flush_i            in   1     taken branch/exception; kill decode slot
//  exe_valid_o        out  1     EXE slot valid
//  exe_pc_o           out  XLEN  EXE PC
//  exe_instr_o        out  32    EXE instruction word
//  exe_op_a_o         out  XLEN  EXE operand a
//  exe_op_b_o         out  XLEN  EXE operand b
//  exe_imm_o          out  XLEN  EXE immediate
//  exe_wr_addr_o      out  5     EXE rd
//  exe_wr_en_o        out  1     EXE writes rd
//  dec_hold_o         out  1     fetch/decode must hold; = stall_core_i & ~flush_i (comb)
//  stall_timeout_o    out  1     sticky watchdog flag
//  perf_stall_cnt_o   out  32    stall-cycle counter (see CONFIGURATION)
//  perf_flush_cnt_o   out  32    flush counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rsn_i=0 at edge): all exe_* outputs 0 except exe_instr_o=NOP (32'h00000013);
//   stall_timeout_o=0, counters=0, FSM=RUN.
//  Latency: 1 cycle. Per edge, priority: reset > flush > stall > capture.
//  - flush_i: bubble into EXE (valid=0, wr_en=0, instr=NOP, ops/imm/pc=0); FSM->RUN.
//  - stall_core_i: same bubble. Decode-side data is not captured; decode re-presents next cycle.
//  - else: capture decode fields; exe_valid_o=dec_valid_i; exe_wr_en_o=dec_wr_en_i&dec_valid_i.
//  Operand select, per side:
//   read addr==0 -> 0 (bypass ignored for x0);
//   else bypass_x_en_i ? bypass_data_x_i : rf_data_x_i.
//  A dec_valid_i=0 slot is captured as a bubble (wr_en forced 0).
//  Watchdog FSM, 2 states:
//   RUN -(stall & ~flush)-> STALLED, cnt=1
//   STALLED, stall: cnt++ (saturate at STALL_TIMEOUT); when cnt==STALL_TIMEOUT set stall_timeout_o
//   STALLED, ~stall or flush: -> RUN, cnt=0
//   stall_timeout_o clears only on reset.
//  Simultaneous flush+stall: flush wins; dec_hold_o=0.
//  Reset mid-stall: next cycle RUN, counters 0.
// CONFIGURATION
//  DEC_EXE_PERF_CNT_EN defined:
//   perf_stall_cnt_o counts edges with stall_core_i & ~flush_i;
//   perf_flush_cnt_o counts edges with flush_i;
//   both 32-bit, saturate at 32'hFFFFFFFF.
//  DEC_EXE_PERF_CNT_EN undefined: no counter flops; both ports tied to 0.
// STRUCTURE
//  Shared package vi_pkg: NOP_INSTR=32'h00000013, OPC_LOAD=7'b0000011, OPC_OP=7'b0110011,
//   FUNCT7_MULDIV=7'b0000001, watchdog state typedef {RUN, STALLED}.
//  Sub-module dec_exe_operand_mux: addr, bypass_en, bypass_data, rf_data -> operand;
//   instantiated twice.
// TESTING
//  1 rs1=5, rf_a=0x11, bypass_a_en=1, bypass_a=0x22, no stall -> next cycle exe_op_a_o=0x22, exe_valid_o=1.
//  2 rs2=0, bypass_b_en=1, bypass_b=0xDEAD -> exe_op_b_o=0.
//  3 stall_core_i high 3 cycles with valid ADD -> 3 bubbles (valid=0, instr=0x13, wr_en=0),
//    dec_hold_o=1; ADD enters EXE the cycle after stall drops.
//  4 flush_i=1 and stall_core_i=1 same cycle -> bubble, dec_hold_o=0; FSM RUN; perf_flush_cnt_o +1, stall count unchanged.
//  5 STALL_TIMEOUT=4, stall held 4 cycles -> stall_timeout_o=1 after 4th edge; stays 1 after stall drops; 0 after reset.
//  6 rsn_i=0 for one edge mid-stall -> all outputs at reset values; with DEC_EXE_PERF_CNT_EN, counters=0.

Source files
------------

// File: rtl/vi_pkg.sv
// rtl/vi_pkg.sv - shared pipeline constants and the stall-watchdog state type
package vi_pkg;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [6:0]  OPC_LOAD      = 7'b0000011;
    localparam logic [6:0]  OPC_OP        = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } wd_state_e;
endpackage

// File: rtl/dec_exe_operand_mux.sv
// rtl/dec_exe_operand_mux.sv - per-operand select between bypass and register-file data
module dec_exe_operand_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr_i,
    input  logic            bypass_en_i,
    input  logic [XLEN-1:0] bypass_data_i,
    input  logic [XLEN-1:0] rf_data_i,
    output logic [XLEN-1:0] operand_o
);
    // x0 always reads zero, even if bypass_ctrl flags a match on it
    always_comb begin
        operand_o = rf_data_i;
        if (addr_i == 5'd0) begin
            operand_o = '0;
        end else if (bypass_en_i) begin
            operand_o = bypass_data_i;
        end
    end
endmodule

// File: rtl/dec_exe_pipe.sv
// rtl/dec_exe_pipe.sv - decode->execute register with bubbles, stall watchdog, perf counters (DEC_EXE_PERF_CNT_EN)
module dec_exe_pipe
    import vi_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            dec_valid_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic [31:0]     dec_instr_i,
    input  logic [4:0]      dec_read_addr_a_i,
    input  logic [4:0]      dec_read_addr_b_i,
    input  logic [XLEN-1:0] rf_data_a_i,
    input  logic [XLEN-1:0] rf_data_b_i,
    input  logic [XLEN-1:0] dec_imm_i,
    input  logic [4:0]      dec_wr_addr_i,
    input  logic            dec_wr_en_i,
    input  logic            bypass_a_en_i,
    input  logic            bypass_b_en_i,
    input  logic [XLEN-1:0] bypass_data_a_i,
    input  logic [XLEN-1:0] bypass_data_b_i,
    input  logic            stall_core_i,
    input  logic            flush_i,
    output logic            exe_valid_o,
    output logic [XLEN-1:0] exe_pc_o,
    output logic [31:0]     exe_instr_o,
    output logic [XLEN-1:0] exe_op_a_o,
    output logic [XLEN-1:0] exe_op_b_o,
    output logic [XLEN-1:0] exe_imm_o,
    output logic [4:0]      exe_wr_addr_o,
    output logic            exe_wr_en_o,
    output logic            dec_hold_o,
    output logic            stall_timeout_o,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
);
    localparam int              CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] T_CNT = CNT_W'(STALL_TIMEOUT);

    logic [XLEN-1:0] op_a, op_b;
    logic            valid_d, valid_q, wr_en_d, wr_en_q;
    logic [XLEN-1:0] pc_d, pc_q, op_a_d, op_a_q, op_b_d, op_b_q, imm_d, imm_q;
    logic [31:0]     instr_d, instr_q;
    logic [4:0]      wr_addr_d, wr_addr_q;
    wd_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic            timeout_d, timeout_q;
    logic            hold;

    dec_exe_operand_mux #(.XLEN(XLEN)) u_mux_a (
        .addr_i        (dec_read_addr_a_i),
        .bypass_en_i   (bypass_a_en_i),
        .bypass_data_i (bypass_data_a_i),
        .rf_data_i     (rf_data_a_i),
        .operand_o     (op_a)
    );

    dec_exe_operand_mux #(.XLEN(XLEN)) u_mux_b (
        .addr_i        (dec_read_addr_b_i),
        .bypass_en_i   (bypass_b_en_i),
        .bypass_data_i (bypass_data_b_i),
        .rf_data_i     (rf_data_b_i),
        .operand_o     (op_b)
    );

    // flush outranks stall, so a killed slot never holds fetch
    assign hold = stall_core_i & ~flush_i;

    always_comb begin
        valid_d   = 1'b0;
        wr_en_d   = 1'b0;
        pc_d      = '0;
        instr_d   = NOP_INSTR;
        op_a_d    = '0;
        op_b_d    = '0;
        imm_d     = '0;
        wr_addr_d = '0;
        if (!flush_i && !stall_core_i) begin
            valid_d   = dec_valid_i;
            wr_en_d   = dec_wr_en_i & dec_valid_i;
            pc_d      = dec_pc_i;
            instr_d   = dec_instr_i;
            op_a_d    = op_a;
            op_b_d    = op_b;
            imm_d     = dec_imm_i;
            wr_addr_d = dec_wr_addr_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (hold) begin
                    state_d = STALLED;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            STALLED: begin
                if (hold) begin
                    cnt_d = (cnt_q == T_CNT) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_d == T_CNT) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= NOP_INSTR;
            op_a_q    <= '0;
            op_b_q    <= '0;
            imm_q     <= '0;
            wr_addr_q <= '0;
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            wr_en_q   <= wr_en_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            imm_q     <= imm_d;
            wr_addr_q <= wr_addr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DEC_EXE_PERF_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold && stall_cnt_q != 32'hFFFFFFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && flush_cnt_q != 32'hFFFFFFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

    assign exe_valid_o     = valid_q;
    assign exe_pc_o        = pc_q;
    assign exe_instr_o     = instr_q;
    assign exe_op_a_o      = op_a_q;
    assign exe_op_b_o      = op_b_q;
    assign exe_imm_o       = imm_q;
    assign exe_wr_addr_o   = wr_addr_q;
    assign exe_wr_en_o     = wr_en_q;
    assign dec_hold_o      = hold;
    assign stall_timeout_o = timeout_q;
endmodule

// File: tb/tb_dec_exe_pipe.sv
// tb/tb_dec_exe_pipe.sv - directed vector bench for dec_exe_pipe
module tb_dec_exe_pipe;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] ADD = 32'h003100B3;

    logic        clk = 1'b0;
    logic        rsn;
    logic        dec_valid;
    logic [31:0] dec_pc, dec_instr, rf_a, rf_b, dec_imm, bd_a, bd_b;
    logic [4:0]  ra, rb, wa;
    logic        we, be_a, be_b, stall, flush;
    logic        exe_valid, exe_we, hold, timeout;
    logic [31:0] exe_pc, exe_instr, exe_a, exe_b, exe_imm, pstall, pflush;
    logic [4:0]  exe_wa;

    int n_chk = 0;
    int n_fail = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    dec_exe_pipe #(.XLEN(32), .STALL_TIMEOUT(4)) dut (
        .clk_i(clk), .rsn_i(rsn), .dec_valid_i(dec_valid), .dec_pc_i(dec_pc),
        .dec_instr_i(dec_instr), .dec_read_addr_a_i(ra), .dec_read_addr_b_i(rb),
        .rf_data_a_i(rf_a), .rf_data_b_i(rf_b), .dec_imm_i(dec_imm),
        .dec_wr_addr_i(wa), .dec_wr_en_i(we), .bypass_a_en_i(be_a), .bypass_b_en_i(be_b),
        .bypass_data_a_i(bd_a), .bypass_data_b_i(bd_b), .stall_core_i(stall), .flush_i(flush),
        .exe_valid_o(exe_valid), .exe_pc_o(exe_pc), .exe_instr_o(exe_instr),
        .exe_op_a_o(exe_a), .exe_op_b_o(exe_b), .exe_imm_o(exe_imm),
        .exe_wr_addr_o(exe_wa), .exe_wr_en_o(exe_we), .dec_hold_o(hold),
        .stall_timeout_o(timeout), .perf_stall_cnt_o(pstall), .perf_flush_cnt_o(pflush)
    );

    // independent model of the perf counters
    always @(posedge clk) begin
        if (!rsn) begin
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (stall && !flush) m_stall <= m_stall + 1;
            if (flush) m_flush <= m_flush + 1;
        end
    end

    typedef struct {
        logic        valid; logic [31:0] pc; logic [31:0] instr;
        logic [4:0]  ra; logic [31:0] rfa; logic bea; logic [31:0] bda;
        logic [4:0]  rb; logic [31:0] rfb; logic beb; logic [31:0] bdb;
        logic [31:0] imm; logic [4:0] wa; logic we; logic stall; logic flush;
        logic        e_valid; logic [31:0] e_pc; logic [31:0] e_instr;
        logic [31:0] e_a; logic [31:0] e_b; logic [31:0] e_imm;
        logic [4:0]  e_wa; logic e_we; logic e_hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_perf();
`ifdef DEC_EXE_PERF_CNT_EN
        chk("perf_stall", pstall, m_stall);
        chk("perf_flush", pflush, m_flush);
`else
        chk("perf_stall_tied", pstall, 0);
        chk("perf_flush_tied", pflush, 0);
`endif
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, exe_valid, 0);
        chk({tag, "_instr"}, exe_instr, NOP);
        chk({tag, "_we"}, exe_we, 0);
        chk({tag, "_pc"}, exe_pc, 0);
        chk({tag, "_opa"}, exe_a, 0);
    endtask

    task automatic idle();
        dec_valid = 0; dec_pc = 0; dec_instr = NOP; ra = 0; rb = 0; rf_a = 0; rf_b = 0;
        dec_imm = 0; wa = 0; we = 0; be_a = 0; be_b = 0; bd_a = 0; bd_b = 0;
        stall = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rsn = 0;
        step();
        rsn = 1;
    endtask

    initial begin
        rsn = 0;
        idle();
        stall = 1;
        step();
        chk_bubble("reset");
        chk("reset_imm", exe_imm, 0);
        chk("reset_wa", exe_wa, 0);
        chk("reset_timeout", timeout, 0);
        chk_perf();
        rsn = 1;
        stall = 0;

        //          v  pc      instr  ra rfa    bea bda    rb rfb    beb bdb      imm    wa we st fl | ev epc     einstr ea     eb     eimm   ewa ewe hold
        vecs[0] = '{1, 32'h100, ADD, 5, 32'h11, 1, 32'h22, 6, 32'h33, 0, 32'h0,    32'h0, 3, 1, 0, 0, 1, 32'h100, ADD, 32'h22, 32'h33, 32'h0, 3, 1, 0};
        vecs[1] = '{1, 32'h104, ADD, 7, 32'h44, 0, 32'h99, 0, 32'h77, 1, 32'hDEAD, 32'h8, 4, 1, 0, 0, 1, 32'h104, ADD, 32'h44, 32'h0,  32'h8, 4, 1, 0};
        vecs[2] = '{1, 32'h108, ADD, 0, 32'h12, 1, 32'h55, 9, 32'h88, 1, 32'h66,   32'h0, 5, 1, 0, 0, 1, 32'h108, ADD, 32'h0,  32'h66, 32'h0, 5, 1, 0};
        vecs[3] = '{0, 32'h0,   NOP, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0,    32'h0, 6, 1, 0, 0, 0, 32'h0,   NOP, 32'h0,  32'h0,  32'h0, 6, 0, 0};
        vecs[4] = '{1, 32'h10C, ADD, 5, 32'h11, 0, 32'h0,  6, 32'h22, 0, 32'h0,    32'h4, 7, 1, 1, 0, 0, 32'h0,   NOP, 32'h0,  32'h0,  32'h0, 0, 0, 1};
        vecs[5] = '{1, 32'h110, ADD, 5, 32'h11, 0, 32'h0,  6, 32'h22, 0, 32'h0,    32'h4, 7, 1, 0, 1, 0, 32'h0,   NOP, 32'h0,  32'h0,  32'h0, 0, 0, 0};
        vecs[6] = '{1, 32'h114, ADD, 5, 32'h11, 0, 32'h0,  6, 32'h22, 0, 32'h0,    32'h4, 7, 1, 1, 1, 0, 32'h0,   NOP, 32'h0,  32'h0,  32'h0, 0, 0, 0};
        vecs[7] = '{1, 32'h118, ADD, 1, 32'hAA, 0, 32'h0,  2, 32'hBB, 1, 32'hCC,   32'h10, 8, 0, 0, 0, 1, 32'h118, ADD, 32'hAA, 32'hCC, 32'h10, 8, 0, 0};

        for (int i = 0; i < 8; i++) begin
            dec_valid = vecs[i].valid; dec_pc = vecs[i].pc; dec_instr = vecs[i].instr;
            ra = vecs[i].ra; rf_a = vecs[i].rfa; be_a = vecs[i].bea; bd_a = vecs[i].bda;
            rb = vecs[i].rb; rf_b = vecs[i].rfb; be_b = vecs[i].beb; bd_b = vecs[i].bdb;
            dec_imm = vecs[i].imm; wa = vecs[i].wa; we = vecs[i].we;
            stall = vecs[i].stall; flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_hold", i), hold, vecs[i].e_hold);
            step();
            chk($sformatf("v%0d_valid", i), exe_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_pc", i), exe_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), exe_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_opa", i), exe_a, vecs[i].e_a);
            chk($sformatf("v%0d_opb", i), exe_b, vecs[i].e_b);
            chk($sformatf("v%0d_imm", i), exe_imm, vecs[i].e_imm);
            chk($sformatf("v%0d_wa", i), exe_wa, vecs[i].e_wa);
            chk($sformatf("v%0d_we", i), exe_we, vecs[i].e_we);
            chk_perf();
        end
        chk("table_timeout", timeout, 0);

        // three-cycle stall with a valid ADD waiting in decode
        idle();
        dec_valid = 1; dec_instr = ADD; dec_pc = 32'h200; ra = 3; rf_a = 32'h5; wa = 9; we = 1;
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d_hold", c), hold, 1);
            step();
            chk_bubble($sformatf("st%0d", c));
        end
        stall = 0;
        step();
        chk("st_add_valid", exe_valid, 1);
        chk("st_add_instr", exe_instr, ADD);
        chk("st_add_opa", exe_a, 32'h5);
        chk("st_add_we", exe_we, 1);
        chk("st_timeout", timeout, 0);
        chk_perf();

        // flush and stall together
        stall = 1; flush = 1;
        #1;
        chk("fs_hold", hold, 0);
        step();
        chk_bubble("fs");
        chk_perf();
        stall = 0; flush = 0;

        // watchdog with STALL_TIMEOUT=4
        do_reset();
        stall = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("wd_edge%0d", c), timeout, (c == 4));
        end
        stall = 0;
        step();
        chk("wd_sticky", timeout, 1);
        step();
        chk("wd_sticky2", timeout, 1);
        do_reset();
        chk("wd_reset", timeout, 0);
        chk_perf();

        // reset in the middle of a stall
        dec_valid = 1; dec_instr = ADD; ra = 3; rf_a = 32'h5; we = 1;
        step();
        stall = 1;
        step();
        step();
        rsn = 0;
        step();
        chk_bubble("rms");
        chk("rms_timeout", timeout, 0);
        chk_perf();
        rsn = 1;
        for (int c = 0; c < 3; c++) step();
        chk("rms_cnt_restart", timeout, 0);
        step();
        chk("rms_cnt_full", timeout, 1);
        stall = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
